// File: rtl/cg_count_match.sv
// Compare/event stage fed by the shared free-running counter.
// Raises a pending event when i_count reaches the programmed compare value,
// in one-shot or auto-advancing periodic mode. Pending events are counted
// (saturating) and retired one per i_ack; o_ovf records lost events.
module cg_count_match #(
    parameter int DATA_WIDTH = 32,
    parameter int PEND_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [DATA_WIDTH-1:0] i_count,
    input  logic                  i_arm,
    input  logic                  i_disarm,
    input  logic                  i_periodic,
    input  logic [DATA_WIDTH-1:0] i_cmp,
    input  logic [DATA_WIDTH-1:0] i_period,
    input  logic                  i_ack,
    output logic                  o_irq,
    output logic [PEND_WIDTH-1:0] o_pend,
    output logic                  o_ovf,
    output logic                  o_armed,
    output logic [DATA_WIDTH-1:0] o_cmp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   cmp_q, cmp_d;
    logic [DATA_WIDTH-1:0]   per_q, per_d;
    logic                    mode_q, mode_d;
    logic                    eq_q, eq_d;
    logic [PEND_WIDTH-1:0]   pend_q, pend_d;
    logic                    ovf_q, ovf_d;

    logic                    w_eq;
    logic                    hit;
    logic [DATA_WIDTH-1:0]   cmp_adv;

    // Saturating increment: the pending count never wraps back to zero.
    function automatic logic [PEND_WIDTH-1:0] pend_sat_inc(input logic [PEND_WIDTH-1:0] p);
        if (p == PEND_MAX) begin
            return p;
        end
        return p + 1'b1;
    endfunction

    // Rising-edge equality detect; eq_q suppresses repeat hits on a stalled counter.
    always_comb begin
        w_eq    = (i_count == cmp_q);
        hit     = (state_q == ARMED) && w_eq && !eq_q;
        cmp_adv = cmp_q + per_q;
    end

    // Pending-event counter and sticky overflow; a hit always counts, even
    // when arm/disarm are asserted in the same cycle.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (hit && !i_ack) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end
            pend_d = pend_sat_inc(pend_q);
        end else if (!hit && i_ack && (pend_q != '0)) begin
            pend_d = pend_q - 1'b1;
        end
        if (i_arm && !i_disarm) begin
            ovf_d = 1'b0;
        end
    end

    // Next-state logic: hit handling first, then arm, then disarm overrides all.
    always_comb begin
        state_d = state_q;
        cmp_d   = cmp_q;
        per_d   = per_q;
        mode_d  = mode_q;
        eq_d    = w_eq;
        if (hit) begin
            if (mode_q && (per_q != '0)) begin
                cmp_d = cmp_adv;
                eq_d  = 1'b0;
            end else begin
                state_d = DONE;
            end
        end
        if (i_disarm) begin
            state_d = IDLE;
        end else if (i_arm) begin
            state_d = ARMED;
            cmp_d   = i_cmp;
            per_d   = i_period;
            mode_d  = i_periodic;
            eq_d    = 1'b0;
        end
    end

    // State and data registers, all cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            cmp_q   <= '0;
            per_q   <= '0;
            mode_q  <= 1'b0;
            eq_q    <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmp_q   <= cmp_d;
            per_q   <= per_d;
            mode_q  <= mode_d;
            eq_q    <= eq_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_irq   = (pend_q != '0);
    assign o_pend  = pend_q;
    assign o_ovf   = ovf_q;
    assign o_armed = (state_q == ARMED);
    assign o_cmp   = cmp_q;

endmodule

// File: tb/tb_cg_count_match.sv
// Scoreboard bench for cg_count_match: the driver pushes expected output
// snapshots, a monitor pops and compares them on the falling clock edge.
// dut_a uses the default pending width, dut_b a 2-bit one for saturation.
module tb_cg_count_match;

    logic        clk;
    logic        rstn;

    logic [31:0] cnt_a, cmp_a, per_a;
    logic        arm_a, dis_a, pm_a, ack_a;
    logic        irq_a, ovf_a, armed_a;
    logic [3:0]  pend_a;
    logic [31:0] ocmp_a;

    logic [31:0] cnt_b, cmp_b, per_b;
    logic        arm_b, dis_b, pm_b, ack_b;
    logic        irq_b, ovf_b, armed_b;
    logic [1:0]  pend_b;
    logic [31:0] ocmp_b;

    int errors;
    int checks;

    typedef struct {
        string       name;
        bit          dut_b;
        logic        irq;
        logic [3:0]  pend;
        logic        ovf;
        logic        armed;
        bit          chk_cmp;
        logic [31:0] cmp;
    } exp_t;

    exp_t sb[$];

    cg_count_match #(.DATA_WIDTH(32), .PEND_WIDTH(4)) dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_count(cnt_a), .i_arm(arm_a),
        .i_disarm(dis_a), .i_periodic(pm_a), .i_cmp(cmp_a), .i_period(per_a),
        .i_ack(ack_a), .o_irq(irq_a), .o_pend(pend_a), .o_ovf(ovf_a),
        .o_armed(armed_a), .o_cmp(ocmp_a)
    );

    cg_count_match #(.DATA_WIDTH(32), .PEND_WIDTH(2)) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_count(cnt_b), .i_arm(arm_b),
        .i_disarm(dis_b), .i_periodic(pm_b), .i_cmp(cmp_b), .i_period(per_b),
        .i_ack(ack_b), .o_irq(irq_b), .o_pend(pend_b), .o_ovf(ovf_b),
        .o_armed(armed_b), .o_cmp(ocmp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string nm, input string fld,
                          input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare every queued snapshot against the live outputs.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (!e.dut_b) begin
                check1(e.name, "irq",   {31'd0, irq_a},   {31'd0, e.irq});
                check1(e.name, "pend",  {28'd0, pend_a},  {28'd0, e.pend});
                check1(e.name, "ovf",   {31'd0, ovf_a},   {31'd0, e.ovf});
                check1(e.name, "armed", {31'd0, armed_a}, {31'd0, e.armed});
                if (e.chk_cmp) check1(e.name, "cmp", ocmp_a, e.cmp);
            end else begin
                check1(e.name, "irq",   {31'd0, irq_b},   {31'd0, e.irq});
                check1(e.name, "pend",  {30'd0, pend_b},  {28'd0, e.pend});
                check1(e.name, "ovf",   {31'd0, ovf_b},   {31'd0, e.ovf});
                check1(e.name, "armed", {31'd0, armed_b}, {31'd0, e.armed});
                if (e.chk_cmp) check1(e.name, "cmp", ocmp_b, e.cmp);
            end
        end
    end

    task automatic push(input string nm, input bit b, input int pend, input logic ovf,
                        input logic armed, input bit chk, input logic [31:0] cmp);
        exp_t e;
        e.name    = nm;
        e.dut_b   = b;
        e.pend    = pend[3:0];
        e.irq     = (pend != 0);
        e.ovf     = ovf;
        e.armed   = armed;
        e.chk_cmp = chk;
        e.cmp     = cmp;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_a_task(input logic [31:0] c, input logic [31:0] p, input logic m);
        cmp_a = c; per_a = p; pm_a = m; arm_a = 1'b1;
        tick();
        arm_a = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        rstn = 1'b0;
        cnt_a = '0; cmp_a = '0; per_a = '0; arm_a = 0; dis_a = 0; pm_a = 0; ack_a = 0;
        cnt_b = '0; cmp_b = '0; per_b = '0; arm_b = 0; dis_b = 0; pm_b = 0; ack_b = 0;
        tick(); tick();
        push("reset_a", 0, 0, 0, 0, 1, 32'd0);
        push("reset_b", 1, 0, 0, 0, 1, 32'd0);
        tick();
        rstn = 1'b1;
        tick();

        // One-shot
        cnt_a = 0;
        arm_a_task(32'd5, 32'd0, 1'b0);
        push("os_arm", 0, 0, 0, 1, 1, 32'd5);
        for (int c = 1; c <= 20; c++) begin
            cnt_a = c;
            tick();
            if (c == 4) push("os_pre", 0, 0, 0, 1, 1, 32'd5);
            if (c == 5) push("os_hit", 0, 1, 0, 0, 1, 32'd5);
        end
        push("os_after", 0, 1, 0, 0, 1, 32'd5);
        ack_a = 1; tick(); ack_a = 0;
        push("os_ack", 0, 0, 0, 0, 0, 32'd0);
        ack_a = 1; tick(); ack_a = 0;
        push("os_ack_zero", 0, 0, 0, 0, 0, 32'd0);

        // Periodic
        cnt_a = 0;
        arm_a_task(32'd4, 32'd3, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            cnt_a = c;
            tick();
            if (c == 4) push("per_first", 0, 1, 0, 1, 1, 32'd7);
        end
        push("per_end", 0, 6, 0, 1, 1, 32'd22);
        for (int k = 0; k < 6; k++) begin
            ack_a = 1; tick(); ack_a = 0;
        end
        push("per_acked", 0, 0, 0, 1, 1, 32'd22);

        // Stalled counter
        cnt_a = 0;
        arm_a_task(32'd5, 32'd1, 1'b1);
        cnt_a = 5;
        tick();
        push("stall_first", 0, 1, 0, 1, 1, 32'd6);
        for (int k = 0; k < 9; k++) tick();
        push("stall_hold", 0, 1, 0, 1, 1, 32'd6);
        for (int c = 6; c <= 8; c++) begin
            cnt_a = c;
            tick();
            push("stall_run", 0, c - 4, 0, 1, 1, c + 1);
        end

        // Wrap-around compare advance
        cnt_a = 32'hFFFF_FFFC;
        arm_a_task(32'hFFFF_FFFE, 32'd4, 1'b1);
        cnt_a = 32'hFFFF_FFFD; tick();
        cnt_a = 32'hFFFF_FFFE; tick();
        push("wrap_hit", 0, 5, 0, 1, 1, 32'h0000_0002);
        cnt_a = 32'hFFFF_FFFF; tick();
        cnt_a = 32'h0; tick();
        cnt_a = 32'h1; tick();
        push("wrap_pre", 0, 5, 0, 1, 1, 32'h0000_0002);
        cnt_a = 32'h2; tick();
        push("wrap_next", 0, 6, 0, 1, 1, 32'h0000_0006);

        // Saturation and overflow on the narrow instance
        cnt_b = 0; cmp_b = 0; per_b = 1; pm_b = 1; arm_b = 1;
        tick();
        arm_b = 0;
        push("sat_arm", 1, 0, 0, 1, 1, 32'd0);
        for (int c = 0; c <= 4; c++) begin
            cnt_b = c;
            tick();
            if (c == 2) push("sat_full", 1, 3, 0, 1, 1, 32'd3);
        end
        push("sat_ovf", 1, 3, 1, 1, 1, 32'd5);
        cnt_b = 5; ack_b = 1; tick(); ack_b = 0;
        push("sat_hit_ack", 1, 3, 1, 1, 1, 32'd6);
        cmp_b = 32'd100; arm_b = 1; tick(); arm_b = 0;
        push("sat_rearm", 1, 3, 0, 1, 1, 32'd100);

        // Arm and disarm together
        cnt_a = 3;
        cmp_a = 32'd50; arm_a = 1; dis_a = 1;
        tick();
        arm_a = 0; dis_a = 0;
        push("arm_dis", 0, 6, 0, 0, 0, 32'd0);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2;
        rstn = 1'b0;
        push("async_rst_a", 0, 0, 0, 0, 1, 32'd0);
        push("async_rst_b", 1, 0, 0, 0, 1, 32'd0);
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            cnt_a = c;
            tick();
        end
        push("post_rst_idle", 0, 0, 0, 0, 1, 32'd0);
        cnt_a = 0;
        arm_a_task(32'd3, 32'd0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            cnt_a = c;
            tick();
        end
        push("post_rst_arm", 0, 1, 0, 0, 1, 32'd3);

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cg_count_match.md
Name: cg_count_match

Overview:
- Compare/event stage directly downstream of the shared free-running counter (CG_counter); consumes its o_count.
- Raises an interrupt-style pending event when the count reaches a programmed compare value.
- One-shot or periodic auto-advancing compare.
- Pending-event counter with ack handshake and sticky overflow.

Parameters:
- DATA_WIDTH, 32: width of i_count, compare and period values.
- PEND_WIDTH, 4: width of the pending-event counter; saturates at 2^PEND_WIDTH-1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  reset, asynchronous, active-low; one clock, asynchronous active-low reset.
- i_count  in  DATA_WIDTH  counter value, driven by the counter's o_count.
- i_arm  in  1  pulse; loads i_cmp/i_period/i_periodic, enters ARMED, clears o_ovf.
- i_disarm  in  1  pulse; returns to IDLE.
- i_periodic  in  1  mode sampled on i_arm: 1 periodic, 0 one-shot.
- i_cmp  in  DATA_WIDTH  compare value, sampled on i_arm.
- i_period  in  DATA_WIDTH  period increment, sampled on i_arm.
- i_ack  in  1  acknowledge one pending event.
- o_irq  out  1  high while o_pend != 0 (combinational from the pend register).
- o_pend  out  PEND_WIDTH  unacknowledged hit count.
- o_ovf  out  1  sticky; a hit occurred while o_pend was saturated.
- o_armed  out  1  state == ARMED.
- o_cmp  out  DATA_WIDTH  current compare register.

Behaviour:
- Reset (async, i_rstn=0): state IDLE, r_cmp=0, r_per=0, r_mode=0, r_eq_q=0, o_pend=0, o_ovf=0, o_irq=0.
- States:
  - IDLE: no hits; i_arm -> ARMED.
  - ARMED: hits detected. A one-shot hit -> DONE. A periodic hit stays ARMED.
  - DONE: no hits; i_arm -> ARMED.
  - i_disarm from any state -> IDLE.
- Match: w_eq = (i_count == r_cmp). hit = (state==ARMED) && w_eq && !r_eq_q.
- r_eq_q update:
  - Default: r_eq_q <= w_eq each cycle.
  - Forced to 0 whenever r_cmp is loaded (arm or periodic advance).
  - Consequence: a stopped counter holding the compare value produces exactly one hit.
- Latency: a hit condition sampled at edge k updates o_pend at edge k, so o_irq is high after edge k.
- Periodic hit: r_cmp <= r_cmp + r_per, modulo 2^DATA_WIDTH (wrap, no carry out).
- Periodic with r_per==0 behaves as one-shot: -> DONE.
- Arming when i_count already equals i_cmp: hit one cycle later, if the count still matches.
- Pending counter:
  - hit and no ack: +1.
  - ack and no hit, pend>0: -1.
  - hit and ack in the same cycle: unchanged.
  - ack with pend==0: ignored.
  - hit with pend at max: pend stays at max, o_ovf <= 1.
- o_ovf is cleared only by i_arm or reset. Pending hits are preserved across i_arm and i_disarm.
- Priority:
  - i_disarm over i_arm when both are asserted.
  - A hit is evaluated against the pre-edge state/r_cmp. Its pend increment takes effect even if i_arm or i_disarm is asserted in the same cycle; the arm/disarm then determines the next state and r_cmp.
- A counter preset jumping onto the compare value counts as a hit. A counter jumping over the compare value does not; no magnitude compare.
- Reset mid-operation: all state is cleared immediately, independent of clock.

Test Plan:
1. One-shot: arm cmp=5, counter counting from 0 -> exactly one hit when count=5; o_irq=1, o_pend=1, state DONE; count 6..20 produces no further hits; i_ack pulse -> o_pend=0, o_irq=0.
2. Periodic: arm cmp=4, period=3, count 0..20 -> hits at 4,7,10,13,16,19; o_pend=6, o_cmp=22; six i_ack pulses -> o_irq=0.
3. Stall: periodic cmp=5, period=1, counter stopped at 5 for 10 cycles -> exactly one hit, o_cmp=6; release counter -> hits at 6,7,8 on consecutive cycles.
4. Wrap: arm periodic cmp=0xFFFF_FFFE, period=4, counter preset to 0xFFFF_FFFC -> hit at 0xFFFF_FFFE, o_cmp=0x0000_0002, next hit at 0x0000_0002.
5. Saturation/ovf (PEND_WIDTH=2): periodic cmp=0, period=1, no ack for 5 hits -> o_pend=3, o_ovf=1. Hit and i_ack in the same cycle -> o_pend stays 3. i_arm -> o_ovf=0, o_pend=3.
6. Control: i_arm and i_disarm together -> IDLE. Assert i_rstn=0 mid-period, between clock edges -> all outputs 0 immediately; after release, no hits until armed.
